// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial WIDTH-bit adder. One full-adder cell and a carry flip-flop
// process the operands one bit per clock, LSB first. The operands are captured
// in parallel on an accepted start, and the parallel sum is presented with a
// one-cycle done pulse.
//
// Parameters
//   WIDTH      operand/sum width in bits (WIDTH >= 1)
//
// Ports
//   clk        clock; all state updates on the rising edge
//   reset      synchronous, active-high reset; overrides everything
//   start      request a new addition; sampled only while busy == 0
//   a, b       operands; captured on the accepting edge only
//   c_in       carry-in; captured on the accepting edge only
//   busy       high while bits are being processed (RUN state)
//   done       one-cycle pulse: sum/c_out hold a new result
//   sum        a + b + c_in mod 2^WIDTH; held until the next result
//   c_out      carry out of bit WIDTH-1; held with sum
//   state_dbg  current FSM state (IDLE=0, RUN=1, DONE=2) for observation
//
// Handshake: an addition is accepted on any rising edge where start == 1 and
// the block is in IDLE or DONE (busy == 0). A start seen while busy == 1 is
// dropped. Exactly WIDTH clocks after acceptance, done is high for one cycle
// and sum/c_out carry the result. Accepting again in the DONE cycle is legal,
// so a held start yields one result every WIDTH+1 cycles.
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic [1:0]       state_dbg
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Datapath registers
    logic [WIDTH-1:0] op_a_q;
    logic [WIDTH-1:0] op_b_q;
    logic [WIDTH-1:0] sum_sh_q;
    logic             carry_q;
    logic [CNT_W-1:0] count_q;
    logic [WIDTH-1:0] sum_q;
    logic             c_out_q;

    // FSM strobes
    logic accept;
    logic last_bit;

    // Full-adder cell and the internal sum register after this edge's shift
    logic             fa_sum;
    logic             fa_carry;
    logic [WIDTH-1:0] sum_shift;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        accept   = 1'b0;
        last_bit = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    accept  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (count_q == LAST_BIT) begin
                    state_d  = DONE;
                    last_bit = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Single full-adder cell on the current LSBs and the carry flip-flop
    // -------------------------------------------------------------------------
    always_comb begin
        fa_sum   = op_a_q[0] ^ op_b_q[0] ^ carry_q;
        fa_carry = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & carry_q) |
                   (op_b_q[0] & carry_q);
    end

    // New sum bits enter at the MSB so that after WIDTH shifts the LSB-first
    // stream lands in natural bit order. With a single bit there is nothing
    // to shift down.
    generate
        if (WIDTH == 1) begin : g_shift_w1
            assign sum_shift = fa_sum;
        end else begin : g_shift_wn
            assign sum_shift = {fa_sum, sum_sh_q[WIDTH-1:1]};
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            op_a_q   <= '0;
            op_b_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            count_q  <= '0;
            sum_q    <= '0;
            c_out_q  <= 1'b0;
        end else if (accept) begin
            op_a_q  <= a;
            op_b_q  <= b;
            carry_q <= c_in;
            count_q <= '0;
        end else if (state_q == RUN) begin
            op_a_q   <= op_a_q >> 1;
            op_b_q   <= op_b_q >> 1;
            sum_sh_q <= sum_shift;
            carry_q  <= fa_carry;
            count_q  <= count_q + CNT_W'(1);
            // The visible result changes only on the final bit, so sum/c_out
            // never show a partially shifted value.
            if (last_bit) begin
                sum_q   <= sum_shift;
                c_out_q <= fa_carry;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs: all decoded straight from registers
    // -------------------------------------------------------------------------
    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign sum       = sum_q;
    assign c_out     = c_out_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Directed bench for serial_adder (WIDTH = 8). The driver pushes the expected
// {c_out, sum} into exp_q whenever an addition is accepted; an independent
// monitor pops and compares on every done pulse. Timing, hold and reset
// behaviour are checked in the main sequence.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             c_out;
    logic [1:0]       state_dbg;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [WIDTH:0] exp_q[$];
    logic [WIDTH:0] mon_exp;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .c_out     (c_out),
        .state_dbg (state_dbg)
    );

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // -------------------------------------------------------------------------
    // Checking helpers
    // -------------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got no event within bound, want event", name);
    endtask

    // -------------------------------------------------------------------------
    // Scoreboard monitor
    // -------------------------------------------------------------------------
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got c_out=%b sum=%h, want no result",
                         c_out, sum);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result", 32'({c_out, sum}), 32'(mon_exp));
            end
        end
    end

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic wait_not_busy();
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout_fail("wait_not_busy");
    endtask

    // Issues one addition; returns #1 after the accepting edge.
    task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic cv, input logic [WIDTH:0] exp, input bit push);
        wait_not_busy();
        a     = av;
        b     = bv;
        c_in  = cv;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (push) exp_q.push_back(exp);
        start = 1'b0;
        // Scramble the inputs: they must not matter after acceptance.
        a     = WIDTH'($urandom);
        b     = WIDTH'($urandom);
        c_in  = 1'($urandom);
    endtask

    // Waits for done, counting busy cycles and optionally checking that the
    // previous result is held while the addition runs.
    task automatic wait_done(input logic [WIDTH:0] held, input bit chk_hold,
                             output int busy_cyc);
        bit found;
        found    = 1'b0;
        busy_cyc = 0;
        for (int n = 0; n < 40 && !found; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                found = 1'b1;
            end else if (busy === 1'b1) begin
                busy_cyc++;
                if (chk_hold) check("held_during_run", 32'({c_out, sum}), 32'(held));
            end
        end
        if (!found) timeout_fail("wait_done");
    endtask

    // -------------------------------------------------------------------------
    // Main sequence
    // -------------------------------------------------------------------------
    initial begin
        int bc;
        int d1;
        int d2;
        int done_cnt;
        logic [WIDTH-1:0] av;
        logic [WIDTH-1:0] bv;
        logic             cv;

        reset = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        c_in  = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_busy",  32'(busy),      32'h0);
        check("reset_done",  32'(done),      32'h0);
        check("reset_sum",   32'(sum),       32'h0);
        check("reset_c_out", 32'(c_out),     32'h0);
        check("reset_state", 32'(state_dbg), 32'h0);

        // 1: zero operands, busy for exactly WIDTH cycles
        issue(8'h00, 8'h00, 1'b0, 9'h000, 1'b1);
        wait_done(9'h000, 1'b1, bc);
        check("t1_busy_cycles", 32'(bc), 32'd8);

        // 2: carry out of the top bit
        issue(8'hFF, 8'h01, 1'b0, 9'h100, 1'b1);
        wait_done(9'h000, 1'b1, bc);
        check("t2a_busy_cycles", 32'(bc), 32'd8);
        issue(8'hA5, 8'h5A, 1'b1, 9'h100, 1'b1);
        wait_done(9'h100, 1'b1, bc);
        check("t2b_busy_cycles", 32'(bc), 32'd8);

        // 3: start pulsed during RUN is ignored
        issue(8'h3C, 8'h0F, 1'b1, 9'h04C, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        a     = 8'hFF;
        b     = 8'hFF;
        c_in  = 1'b1;
        start = 1'b1;
        check("t3_busy_at_pulse", 32'(busy), 32'h1);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(9'h100, 1'b1, bc);
        check("t3_remaining_busy", 32'(bc), 32'd5);
        repeat (3) @(negedge clk);
        check("t3_idle_after", 32'(state_dbg), 32'h0);

        // 4: reset in the middle of a run discards it
        issue(8'h80, 8'h80, 1'b0, 9'h000, 1'b0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("t4_busy",  32'(busy),  32'h0);
        check("t4_done",  32'(done),  32'h0);
        check("t4_sum",   32'(sum),   32'h0);
        check("t4_c_out", 32'(c_out), 32'h0);
        done_cnt = 0;
        repeat (15) begin
            @(negedge clk);
            if (done === 1'b1) done_cnt++;
        end
        check("t4_no_done", 32'(done_cnt), 32'd0);

        // 5: start held high across DONE -> back-to-back results
        wait_not_busy();
        a     = 8'h12;
        b     = 8'h34;
        c_in  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back(9'h046);
        a    = 8'hF0;
        b    = 8'h20;
        c_in = 1'b1;
        wait_done(9'h000, 1'b1, bc);
        check("t5a_busy_cycles", 32'(bc), 32'd8);
        d1 = cyc;
        exp_q.push_back(9'h111);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(9'h046, 1'b1, bc);
        check("t5b_busy_cycles", 32'(bc), 32'd8);
        d2 = cyc;
        check("t5_done_period", 32'(d2 - d1), 32'd9);
        @(negedge clk);
        check("t5_done_one_cycle", 32'(done), 32'h0);
        check("t5_result_held", 32'({c_out, sum}), 32'h111);

        // 6: corner operands and random operands against a+b+c_in
        for (int i = 0; i < 8; i++) begin
            av = (i & 1) ? 8'hFF : 8'h00;
            bv = (i & 2) ? 8'hFF : 8'h00;
            cv = (i & 4) ? 1'b1 : 1'b0;
            issue(av, bv, cv, {1'b0, av} + {1'b0, bv} + 9'(cv), 1'b1);
        end
        for (int i = 0; i < 1000; i++) begin
            av = WIDTH'($urandom_range(0, 255));
            bv = WIDTH'($urandom_range(0, 255));
            cv = 1'($urandom_range(0, 1));
            issue(av, bv, cv, {1'b0, av} + {1'b0, bv} + 9'(cv), 1'b1);
        end

        // Drain
        for (int n = 0; n < 40 && exp_q.size() != 0; n++) @(negedge clk);
        if (exp_q.size() != 0) timeout_fail("drain");
        repeat (2) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
